// File: rtl/byte_unstriping_pkg.sv
// Shared PHY constants for the two-lane receive merger.
package byte_unstriping_pkg;
   localparam int   PHY_WORD_W = 32;
   localparam logic LANE_0     = 1'b0;
   localparam logic LANE_1     = 1'b1;
endpackage

// File: rtl/byte_unstriping_lane_fifo.sv
// Per-lane skew buffer: circular FIFO whose head word is visible combinationally.
module lane_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk_2f,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head_reg;
   logic [AW-1:0]    tail_reg;
   logic [AW:0]      count_reg;

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push) tail_reg <= tail_reg + 1'b1;
         if (pop)  head_reg <= head_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // When full, tail equals head: the popped word is read before this write lands.
   always_ff @(posedge clk_2f) begin
      if (push) mem[tail_reg] <= din;
   end

   assign dout  = mem[head_reg];
   assign count = count_reg;
   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
endmodule

// File: rtl/byte_unstriping.sv
// Merges two skewed 32-bit lanes into one stream in strict lane 0 / lane 1 order.
module byte_unstriping
   import byte_unstriping_pkg::*;
#(
   parameter int WIDTH = PHY_WORD_W,
   parameter int DEPTH = 4
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic [WIDTH-1:0] lane_0,
   input  logic             valid_0,
   input  logic [WIDTH-1:0] lane_1,
   input  logic             valid_1,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             next_lane,
   output logic             overflow_0,
   output logic             overflow_1
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [1:0]       valid_in;
   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       full;
   logic [1:0]       empty;
   logic [1:0]       drop;
   logic [WIDTH-1:0] din  [2];
   logic [WIDTH-1:0] head [2];
   logic [AW:0]      count [2];

   logic [WIDTH-1:0] data_out_reg;
   logic             valid_out_reg;
   logic             next_lane_reg;
   logic [1:0]       overflow_reg;

   assign valid_in = {valid_1, valid_0};
   assign din[0]   = lane_0;
   assign din[1]   = lane_1;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         // Only the lane the sequencer expects may pop; the other lane just waits.
         assign pop[gi]  = (int'(next_lane_reg) == gi) && !empty[gi];
         assign push[gi] = valid_in[gi] && (!full[gi] || pop[gi]);
         assign drop[gi] = valid_in[gi] && (count[gi] == CNT_FULL) && !pop[gi];

         lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk_2f (clk_2f),
            .reset  (reset),
            .push   (push[gi]),
            .pop    (pop[gi]),
            .din    (din[gi]),
            .dout   (head[gi]),
            .count  (count[gi]),
            .full   (full[gi]),
            .empty  (empty[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         data_out_reg  <= '0;
         valid_out_reg <= 1'b0;
         next_lane_reg <= LANE_0;
         overflow_reg  <= 2'b00;
      end else begin
         if (|pop) begin
            data_out_reg  <= (next_lane_reg == LANE_1) ? head[1] : head[0];
            valid_out_reg <= 1'b1;
            next_lane_reg <= ~next_lane_reg;
         end else begin
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
         end
         overflow_reg <= overflow_reg | drop;
      end
   end

   assign data_out   = data_out_reg;
   assign valid_out  = valid_out_reg;
   assign next_lane  = next_lane_reg;
   assign overflow_0 = overflow_reg[0];
   assign overflow_1 = overflow_reg[1];
endmodule

// File: tb/tb_byte_unstriping.sv
// Randomised and directed checks of byte_unstriping against a queue-based lane model.
module tb_byte_unstriping;
   localparam int D = 4;

   logic        clk_2f = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] lane_0 = '0;
   logic        valid_0 = 1'b0;
   logic [31:0] lane_1 = '0;
   logic        valid_1 = 1'b0;
   logic [31:0] data_out;
   logic        valid_out;
   logic        next_lane;
   logic        overflow_0;
   logic        overflow_1;

   byte_unstriping #(.WIDTH(32), .DEPTH(D)) dut (
      .clk_2f     (clk_2f),
      .reset      (reset),
      .lane_0     (lane_0),
      .valid_0    (valid_0),
      .lane_1     (lane_1),
      .valid_1    (valid_1),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .next_lane  (next_lane),
      .overflow_0 (overflow_0),
      .overflow_1 (overflow_1)
   );

   always #5 clk_2f = ~clk_2f;

   int errors = 0;
   int checks = 0;
   int n_pushed = 0;

   // Model: one queue per lane, the lane expected next, sticky drop flags.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] obs[$];
   logic [31:0] exp_q[$];
   logic        m_next = 1'b0;
   logic        m_valid = 1'b0;
   logic [31:0] m_data = '0;
   logic        m_ov0 = 1'b0;
   logic        m_ov1 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic chk_obs(input string name);
      chk({name, "_len"}, 32'(obs.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
         chk(name, obs[i], exp_q[i]);
   endtask

   task automatic step(input logic r, input logic v0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] d1);
      reset = r; valid_0 = v0; lane_0 = d0; valid_1 = v1; lane_1 = d1;
      @(posedge clk_2f);
      if (r) begin
         q0.delete(); q1.delete();
         m_next = 1'b0; m_valid = 1'b0; m_data = '0; m_ov0 = 1'b0; m_ov1 = 1'b0;
      end else begin
         m_valid = 1'b0; m_data = '0;
         if (!m_next && q0.size() > 0) begin
            m_data = q0.pop_front(); m_valid = 1'b1; m_next = 1'b1;
         end else if (m_next && q1.size() > 0) begin
            m_data = q1.pop_front(); m_valid = 1'b1; m_next = 1'b0;
         end
         if (v0) begin
            if (q0.size() < D) begin q0.push_back(d0); n_pushed++; end
            else m_ov0 = 1'b1;
         end
         if (v1) begin
            if (q1.size() < D) begin q1.push_back(d1); n_pushed++; end
            else m_ov1 = 1'b1;
         end
      end
      #1;
      $display("t=%0t rst=%b v0=%b d0=%h v1=%b d1=%h -> out=%h vo=%b nl=%b ov=%b%b",
               $time, r, v0, d0, v1, d1, data_out, valid_out, next_lane, overflow_1, overflow_0);
      chk("data_out", data_out, m_data);
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("next_lane", 32'(next_lane), 32'(m_next));
      chk("overflow_0", 32'(overflow_0), 32'(m_ov0));
      chk("overflow_1", 32'(overflow_1), 32'(m_ov1));
      if (valid_out === 1'b1) obs.push_back(data_out);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      // Reset state
      step(1'b1, 1'b0, '0, 1'b0, '0);
      step(1'b1, 1'b0, '0, 1'b0, '0);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_data", data_out, 32'd0);
      chk("rst_next", 32'(next_lane), 32'd0);

      // Basic pair, one-cycle latency
      obs.delete();
      step(1'b0, 1'b1, 32'hA000_0000, 1'b0, '0);
      step(1'b0, 1'b0, '0, 1'b1, 32'hB000_0000);
      chk("t1_first", data_out, 32'hA000_0000);
      chk("t1_first_v", 32'(valid_out), 32'd1);
      step(1'b0, 1'b0, '0, 1'b0, '0);
      chk("t1_second", data_out, 32'hB000_0000);

      // Lane 1 arrives early; output stalls on lane 0
      obs.delete();
      step(1'b0, 1'b0, '0, 1'b1, 32'hB1);
      idle(2);
      chk("t2_stall_v", 32'(valid_out), 32'd0);
      chk("t2_stall_nl", 32'(next_lane), 32'd0);
      step(1'b0, 1'b1, 32'hA1, 1'b0, '0);
      idle(3);
      exp_q = '{32'hA1, 32'hB1};
      chk_obs("t2_seq");

      // Lane 0 overflow, then lane 1 catches up
      step(1'b1, 1'b0, '0, 1'b0, '0);
      obs.delete();
      for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 32'(i), 1'b0, '0);
      chk("t3_ov0", 32'(overflow_0), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, 32'h11 + 32'(i));
      idle(8);
      exp_q = '{32'h1, 32'h11, 32'h2, 32'h12, 32'h3, 32'h13, 32'h4, 32'h14, 32'h5};
      chk_obs("t3_seq");

      // Push into a full lane 1 on the edge it is popped
      step(1'b1, 1'b0, '0, 1'b0, '0);
      obs.delete();
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, '0, 1'b1, 32'hE0 + 32'(i));
      step(1'b0, 1'b1, 32'hAA, 1'b0, '0);
      idle(1);
      chk("t4_nl", 32'(next_lane), 32'd1);
      step(1'b0, 1'b0, '0, 1'b1, 32'hE5);
      chk("t4_ov1", 32'(overflow_1), 32'd0);
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 32'hF0 + 32'(i), 1'b0, '0);
      idle(6);
      exp_q = '{32'hAA, 32'hE1, 32'hF1, 32'hE2, 32'hF2, 32'hE3, 32'hF3,
                32'hE4, 32'hF4, 32'hE5, 32'hF5};
      chk_obs("t4_seq");

      // Reset mid-stream clears buffers and flags
      step(1'b1, 1'b0, '0, 1'b0, '0);
      for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 32'h70 + 32'(i), 1'b0, '0);
      chk("t5_ov0_set", 32'(overflow_0), 32'd1);
      step(1'b1, 1'b0, '0, 1'b0, '0);
      chk("t5_rst_v", 32'(valid_out), 32'd0);
      chk("t5_rst_ov0", 32'(overflow_0), 32'd0);
      obs.delete();
      step(1'b0, 1'b1, 32'hC0, 1'b1, 32'hD0);
      idle(4);
      exp_q = '{32'hC0, 32'hD0};
      chk_obs("t5_seq");

      // Random skew soak without overflow
      step(1'b1, 1'b0, '0, 1'b0, '0);
      obs.delete();
      n_pushed = 0;
      for (int c = 0; c < 600; c++) begin
         logic v0, v1;
         v0 = ($urandom_range(0, 99) < 55) && (q0.size() < D);
         v1 = ($urandom_range(0, 99) < 55) && (q1.size() < D);
         step(1'b0, v0, $urandom, v1, $urandom);
      end
      idle(12);
      chk("soak_count", 32'(obs.size()), 32'(n_pushed - q0.size() - q1.size()));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
